// File: rtl/memory_playback_sequencer.sv
// Memory read-side sequencer: fetches notes, times them per beat (autoplay) or waits for the matching key (learning).
// Optional macro SEQ_LOOP_EN: autoplay songs repeat from note 0 instead of ending with a done pulse.
module memory_playback_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH_BIT   = 8,
  parameter int STATE_WIDTH = 2,
  parameter int BEAT_CYCLES = 25_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STATE_WIDTH-1:0] current_state,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   key_valid,
  input  logic [DATA_WIDTH-3:0]  key_code,
  input  logic [DATA_WIDTH-1:0]  mem_data,
  input  logic                   mem_ready,
  input  logic [DEPTH_BIT-1:0]   mem_count,
  output logic                   mem_read_en,
  output logic                   mem_read_rst,
  output logic [DATA_WIDTH-3:0]  note_out,
  output logic                   note_valid,
  output logic [DEPTH_BIT-1:0]   note_index,
  output logic                   busy,
  output logic                   done,
  output logic                   miss
);

  localparam int CW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(BEAT_CYCLES - 1);
  localparam logic [STATE_WIDTH-1:0] MODE_AUTO  = STATE_WIDTH'(0);
  localparam logic [STATE_WIDTH-1:0] MODE_LEARN = STATE_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_REWIND, S_FETCH, S_WAIT, S_PLAY, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [STATE_WIDTH-1:0] mode_q, mode_d;
  logic [DATA_WIDTH-3:0]  note_q, note_d;
  logic [2:0]             beats_q, beats_d;
  logic [2:0]             beat_q, beat_d;
  logic [CW-1:0]          cyc_q, cyc_d;
  logic [DEPTH_BIT-1:0]   idx_q, idx_d;
  logic                   miss_q, miss_d;

  logic                   abort;
  logic                   is_auto;
  logic                   note_done;
  logic [DEPTH_BIT-1:0]   last_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      note_q  <= '0;
      beats_q <= '0;
      beat_q  <= '0;
      cyc_q   <= '0;
      idx_q   <= '0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      note_q  <= note_d;
      beats_q <= beats_d;
      beat_q  <= beat_d;
      cyc_q   <= cyc_d;
      idx_q   <= idx_d;
      miss_q  <= miss_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    note_d    = note_q;
    beats_d   = beats_q;
    beat_d    = beat_q;
    cyc_d     = cyc_q;
    idx_d     = idx_q;
    miss_d    = 1'b0;
    note_done = 1'b0;
    is_auto   = (mode_q == MODE_AUTO);
    last_idx  = mem_count - DEPTH_BIT'(1);
    // The mode latched at start is the reference for detecting a mode change.
    abort     = (state_q != S_IDLE) && (stop || (current_state != mode_q));

    case (state_q)
      S_IDLE: begin
        if (start && !stop && (current_state == MODE_AUTO || current_state == MODE_LEARN)) begin
          state_d = S_REWIND;
          mode_d  = current_state;
        end
      end
      S_REWIND: begin
        idx_d   = '0;
        state_d = (mem_count == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (mem_ready) begin
          note_d  = mem_data[DATA_WIDTH-1:2];
          beats_d = {1'b0, mem_data[1:0]} + 3'd1;
          cyc_d   = '0;
          beat_d  = '0;
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (is_auto) begin
          if (cyc_q == CYC_LAST) begin
            cyc_d = '0;
            if (beat_q == beats_q - 3'd1) note_done = 1'b1;
            else                          beat_d    = beat_q + 3'd1;
          end else begin
            cyc_d = cyc_q + CW'(1);
          end
        end else if (key_valid) begin
          if (key_code == note_q) note_done = 1'b1;
          else                    miss_d    = 1'b1;
        end
        if (note_done) begin
          if (idx_q >= last_idx) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + DEPTH_BIT'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
`ifdef SEQ_LOOP_EN
        state_d = is_auto ? S_REWIND : S_IDLE;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) begin
      note_d = '0;
      idx_d  = '0;
    end

    if (abort) begin
      state_d = S_IDLE;
      note_d  = '0;
      idx_d   = '0;
      cyc_d   = '0;
      beat_d  = '0;
      miss_d  = 1'b0;
    end
  end

  assign mem_read_en  = (state_q == S_FETCH);
  assign mem_read_rst = (state_q == S_REWIND);
  assign note_valid   = (state_q == S_PLAY);
  assign note_out     = note_q;
  assign note_index   = idx_q;
  assign busy         = (state_q != S_IDLE);
  assign miss         = miss_q;
`ifdef SEQ_LOOP_EN
  assign done         = (state_q == S_DONE) && !is_auto && !abort;
`else
  assign done         = (state_q == S_DONE) && !abort;
`endif

endmodule

// File: doc/memory_playback_sequencer.md
# memory_playback_sequencer

Sequencer that drives the internal memory unit's read side for the autoplay and learning modes. It issues single-cycle read requests and waits for the memory's `output_ready`. It then times each note at a programmable tempo (autoplay) or holds it until the player presses the matching key (learning). Finally it presents the current note to the tone generator and LED display. It sits between the top-level mode FSM and the memory unit.

## Interface
- `DATA_WIDTH`, 8: memory word width. `[DATA_WIDTH-1:2]` is the note code; `[1:0]` is the length, meaning `len+1` beats.
- `DEPTH_BIT`, 8: width of the memory's `duration` (note count) and of the note index.
- `STATE_WIDTH`, 2: mode code width. `AUTOPLAY`=0, `LEARNING`=1; other codes mean inactive.
- `BEAT_CYCLES`, 25_000_000: clock cycles per beat.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `current_state` in `STATE_WIDTH`: top-level mode.
- `start` in 1: one-cycle pulse that begins playback from note 0.
- `stop` in 1: one-cycle pulse that aborts playback.
- `key_valid` in 1: one-cycle pulse on a player key press.
- `key_code` in `DATA_WIDTH-2`: code of the pressed note.
- `mem_data` in `DATA_WIDTH`: memory `data_out`.
- `mem_ready` in 1: memory `output_ready`; `mem_data` is valid when it is high.
- `mem_count` in `DEPTH_BIT`: memory `duration`, the number of stored notes.
- `mem_read_en` out 1: read request to memory, one cycle per note.
- `mem_read_rst` out 1: rewinds the memory read pointer to 0.
- `note_out` out `DATA_WIDTH-2`: note code currently sounding.
- `note_valid` out 1: `note_out` should be played or displayed.
- `note_index` out `DEPTH_BIT`: 0-based index of the current note.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `done` out 1: one-cycle pulse when the last note completes.
- `miss` out 1: one-cycle pulse on a wrong key in learning mode.

## Operation
- States: IDLE, REWIND, FETCH, WAIT, PLAY, DONE.
- IDLE:
  - All outputs are 0.
  - On `start` with `current_state` ∈ {0,1}, go to REWIND. Otherwise `start` is ignored.
- REWIND:
  - Assert `mem_read_rst` for 1 cycle and clear `note_index`.
  - If `mem_count`==0, go to DONE; otherwise go to FETCH.
- FETCH: assert `mem_read_en` for exactly 1 cycle, then go to WAIT.
- WAIT:
  - Hold until `mem_ready`=1.
  - Then latch `note_out` = `mem_data[DATA_WIDTH-1:2]` and beats = `mem_data[1:0]`+1.
  - Clear the cycle and beat counters, and go to PLAY.
- PLAY, autoplay (`current_state`=0):
  - Count `BEAT_CYCLES` cycles per beat.
  - When the final cycle of the final beat completes, the note is finished.
- PLAY, learning (`current_state`=1):
  - The note lengths are ignored.
  - A `key_valid` with `key_code`==`note_out` finishes the note.
  - A `key_valid` with a mismatched code pulses `miss` and stays in PLAY.
- Note finished:
  - If `note_index`==`mem_count`-1, go to DONE.
  - Otherwise increment `note_index` and go to FETCH.
- DONE:
  - Pulse `done` for 1 cycle, then go to IDLE.
  - With `SEQ_LOOP_EN` in autoplay, go to REWIND instead, with no `done` pulse.
- `note_valid` is 1 only in PLAY.
- Abort:
  - Applies when `stop`=1, or when `current_state` changes while `busy` is high.
  - From any non-IDLE state, the next state is IDLE.
  - Outputs clear on that edge and no `done` pulse is issued.
  - Abort has priority over every other transition.
- Simultaneous `start` and `stop` in IDLE: `stop` wins and the FSM stays in IDLE.
- `start` while busy is ignored.
- Counters:
  - The cycle counter is `$clog2(BEAT_CYCLES)` bits and wraps to 0 at `BEAT_CYCLES`-1.
  - The beat counter is 3 bits.
  - `note_index` never exceeds `mem_count`-1.

## Timing
- Reset: state IDLE, and every output, counter and latch is 0.
- Reset mid-playback behaves like abort, but all latches are also cleared.
- `start` to the `mem_read_rst` pulse: 1 cycle. Then `mem_read_en` follows 1 cycle later.
- `mem_ready` high in WAIT: `note_valid` rises on the next edge.
- Autoplay note length: `note_valid` stays high for exactly `beats`×`BEAT_CYCLES` cycles.
- Inter-note gap: the gap between notes is FETCH (1 cycle) plus WAIT (≥1 cycle), with `note_valid` low throughout.
- A `mem_ready` that arrives while the FSM is not in WAIT is ignored.

## Configuration
- `SEQ_LOOP_EN` defined: in autoplay, DONE returns to REWIND and the song repeats until `stop` or a mode change; `done` never pulses in autoplay. Learning mode is unaffected.
- `SEQ_LOOP_EN` undefined: playback always ends at DONE with a `done` pulse, then returns to IDLE.

## Test plan
- Autoplay, `BEAT_CYCLES`=4, `mem_count`=3, words {0x05,0x0A,0x13} (len fields 1,2,3, so 2,3,4 beats), memory replies `mem_ready` 1 cycle after read -> `note_out` = 1,2,4 with `note_valid` high 8, 12 and 16 cycles, then a single `done` pulse, then IDLE.
- Learning, word 0x0C (note 3) -> `key_code`=2 pulses `miss` and the note holds; `key_code`=3 advances `note_index` to 1.
- `mem_count`=0 with `start` -> one `mem_read_rst`, no `mem_read_en`, a `done` pulse 2 cycles after `start`.
- `stop` asserted in the middle of a PLAY beat -> IDLE on the next edge, all outputs 0, no `done`; a following `start` begins again from note 0.
- `current_state` switched from 0 to 2 during WAIT, with a late `mem_ready` -> abort to IDLE and the late `mem_ready` is ignored; `rst` pulse during PLAY -> all outputs 0 on the next edge.
- `SEQ_LOOP_EN` defined, autoplay with 2 notes -> REWIND follows the last note, `note_index` returns to 0, no `done` pulse over 3 loops.
